// File: rtl/pool_window_buffer_if.sv
// Stream interface for pool_window_buffer: a raster pixel stream in, 2x2 windows out.
// The slave modport is the window former; the master modport is its upstream/downstream environment.
interface pool_window_buffer_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] pix_in;
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] win00;
   logic [DATA_W-1:0] win01;
   logic [DATA_W-1:0] win10;
   logic [DATA_W-1:0] win11;
   logic              win_valid;
   logic              win_ready;
   logic              win_last;
   logic              frame_done;

   modport slave (
      input  pix_in, pix_valid, win_ready,
      output pix_ready, win00, win01, win10, win11, win_valid, win_last, frame_done
   );

   modport master (
      output pix_in, pix_valid, win_ready,
      input  pix_ready, win00, win01, win10, win11, win_valid, win_last, frame_done
   );
endinterface

// File: rtl/pool_window_buffer.sv
// Streaming stride-2 2x2 window former: buffers one even row and emits each window
// in parallel, one window deep, with valid/ready on both sides.
module pool_window_buffer #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input logic               clk,
   input logic               rst_n,
   pool_window_buffer_if.slave bus
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

   logic [DATA_W-1:0] line_q [IMG_W];

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] win00_q, win00_d, win01_q, win01_d;
   logic [DATA_W-1:0] win10_q, win10_d, win11_q, win11_d;
   logic              win_valid_q, win_valid_d;
   logic              win_last_q, win_last_d;
   logic              frame_done_q, frame_done_d;

   logic              pix_acc;
   logic              win_acc;
   logic              win_load;
   logic              col_last;
   logic              row_last;

   // Input stalls whenever a window is held but not taken this cycle.
   assign bus.pix_ready = !win_valid_q || bus.win_ready;
   assign pix_acc       = bus.pix_valid && bus.pix_ready;
   assign win_acc       = win_valid_q && bus.win_ready;
   assign win_load      = pix_acc && row_q[0] && col_q[0];
   assign col_last      = (col_q == COL_LAST);
   assign row_last      = (row_q == ROW_LAST);

   always_comb begin
      // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      win00_d      = win00_q;
      win01_d      = win01_q;
      win10_d      = win10_q;
      win11_d      = win11_q;
      win_valid_d  = win_valid_q;
      win_last_d   = win_last_q;
      frame_done_d = win_acc && win_last_q;

      if (pix_acc) begin
         col_d = col_last ? '0 : col_q + COL_ONE;
         if (col_last) begin
            row_d = row_last ? '0 : row_q + ROW_ONE;
         end
         if (row_q[0] && !col_q[0]) begin
            hold_d = bus.pix_in;
         end
      end

      // A new window loading on the same edge as an accept keeps win_valid high.
      if (win_load) begin
         win00_d     = line_q[col_q - COL_ONE];
         win01_d     = line_q[col_q];
         win10_d     = hold_q;
         win11_d     = bus.pix_in;
         win_valid_d = 1'b1;
         win_last_d  = row_last && col_last;
      end else if (win_acc) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         win00_q      <= '0;
         win01_q      <= '0;
         win10_q      <= '0;
         win11_q      <= '0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         win00_q      <= win00_d;
         win01_q      <= win01_d;
         win10_q      <= win10_d;
         win11_q      <= win11_d;
         win_valid_q  <= win_valid_d;
         win_last_q   <= win_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // NOTE: the line buffer has no reset; each entry is written on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (pix_acc && !row_q[0]) begin
         line_q[col_q] <= bus.pix_in;
      end
   end

   assign bus.win00      = win00_q;
   assign bus.win01      = win01_q;
   assign bus.win10      = win10_q;
   assign bus.win11      = win11_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.win_last   = win_last_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: a 4x4 instance for hand-computed windows
// and a 28x28 instance for a randomly gapped full frame against a window model.
module tb_pool_window_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] q4[$];
   logic [63:0] q28[$];
   logic [63:0] exp28[$];
   logic [15:0] img28 [784];
   int          fd4 = 0;
   int          fd28 = 0;
   bit          rand_rdy = 1'b0;

   pool_window_buffer_if #(.DATA_W(16)) if4 ();
   pool_window_buffer_if #(.DATA_W(16)) if28 ();

   pool_window_buffer #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(if4)
   );
   pool_window_buffer #(.DATA_W(16), .IMG_W(28), .IMG_H(28)) dut28 (
      .clk(clk), .rst_n(rst_n), .bus(if28)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] w4(input int a, input int b, input int c, input int d);
      return {16'(a), 16'(b), 16'(c), 16'(d)};
   endfunction

   // Accepted windows and frame_done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (if4.win_valid && if4.win_ready) q4.push_back({if4.win00, if4.win01, if4.win10, if4.win11});
      if (if4.frame_done) fd4++;
      if (if28.win_valid && if28.win_ready) q28.push_back({if28.win00, if28.win01, if28.win10, if28.win11});
      if (if28.frame_done) fd28++;
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         if28.win_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic push4(input logic [15:0] v);
      if4.pix_in    = v;
      if4.pix_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (if4.pix_ready) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("push4_timeout", 64'(0), 64'(1));
      if4.pix_valid = 1'b0;
   endtask

   task automatic push28(input logic [15:0] v);
      if28.pix_in    = v;
      if28.pix_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (if28.pix_ready) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("push28_timeout", 64'(0), 64'(1));
      if28.pix_valid = 1'b0;
   endtask

   task automatic wait_q4(input int n);
      for (int i = 0; i < 300 && q4.size() < n; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_base4(input string tag, input int off);
      check({tag, "_w0"}, q4[off + 0], w4(0, 1, 4, 5));
      check({tag, "_w1"}, q4[off + 1], w4(2, 3, 6, 7));
      check({tag, "_w2"}, q4[off + 2], w4(8, 9, 12, 13));
      check({tag, "_w3"}, q4[off + 3], w4(10, 11, 14, 15));
   endtask

   initial begin
      if4.pix_in = '0;  if4.pix_valid = 1'b0;  if4.win_ready = 1'b1;
      if28.pix_in = '0; if28.pix_valid = 1'b0; if28.win_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_win_valid", 64'(if4.win_valid), 64'(0));
      check("rst_win_last", 64'(if4.win_last), 64'(0));
      check("rst_frame_done", 64'(if4.frame_done), 64'(0));
      check("rst_window", {if4.win00, if4.win01, if4.win10, if4.win11}, 64'(0));
      check("rst_pix_ready", 64'(if4.pix_ready), 64'(1));

      // Continuous 4x4 frame, win_ready=1: window appears the cycle after pixels 5,7,13,15
      q4.delete(); fd4 = 0;
      for (int p = 0; p < 16; p++) begin
         push4(16'(p));
         if (((p / 4) % 2 == 1) && (p % 2 == 1)) begin
            check($sformatf("s1_valid_p%0d", p), 64'(if4.win_valid), 64'(1));
            check($sformatf("s1_win_p%0d", p), {if4.win00, if4.win01, if4.win10, if4.win11},
                  w4(p - 5, p - 4, p - 1, p));
            check($sformatf("s1_last_p%0d", p), 64'(if4.win_last), 64'(p == 15));
         end else begin
            check($sformatf("s1_valid_p%0d", p), 64'(if4.win_valid), 64'(0));
         end
      end
      if4.pix_valid = 1'b0;
      @(posedge clk);
      #1;
      check("s1_frame_done_pulse", 64'(if4.frame_done), 64'(1));
      check("s1_valid_drained", 64'(if4.win_valid), 64'(0));
      @(posedge clk);
      #1;
      check("s1_frame_done_low", 64'(if4.frame_done), 64'(0));
      check("s1_n_windows", 64'(q4.size()), 64'(4));
      check_base4("s1", 0);
      check("s1_fd_count", 64'(fd4), 64'(1));

      // Stall: win_ready low for 5 cycles with pixel 6 pending
      q4.delete(); fd4 = 0;
      for (int p = 0; p < 6; p++) push4(16'(p));
      if4.win_ready = 1'b0;
      if4.pix_in    = 16'd6;
      if4.pix_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("s2_stall_ready_%0d", i), 64'(if4.pix_ready), 64'(0));
         check($sformatf("s2_stall_valid_%0d", i), 64'(if4.win_valid), 64'(1));
         check($sformatf("s2_stall_win_%0d", i), {if4.win00, if4.win01, if4.win10, if4.win11},
               w4(0, 1, 4, 5));
      end
      @(posedge clk);
      #1;
      if4.win_ready = 1'b1;
      for (int p = 6; p < 16; p++) push4(16'(p));
      if4.pix_valid = 1'b0;
      wait_q4(4);
      check("s2_n_windows", 64'(q4.size()), 64'(4));
      check_base4("s2", 0);
      check("s2_fd_count", 64'(fd4), 64'(1));

      // Two frames back-to-back, second frame 0xFFFF-k
      q4.delete(); fd4 = 0;
      for (int p = 0; p < 16; p++) push4(16'(p));
      for (int k = 0; k < 16; k++) push4(16'(16'hFFFF - k));
      if4.pix_valid = 1'b0;
      wait_q4(8);
      check("s3_n_windows", 64'(q4.size()), 64'(8));
      check_base4("s3a", 0);
      check("s3b_w0", q4[4], w4(16'hFFFF, 16'hFFFE, 16'hFFFB, 16'hFFFA));
      check("s3b_w1", q4[5], w4(16'hFFFD, 16'hFFFC, 16'hFFF9, 16'hFFF8));
      check("s3b_w2", q4[6], w4(16'hFFF7, 16'hFFF6, 16'hFFF3, 16'hFFF2));
      check("s3b_w3", q4[7], w4(16'hFFF5, 16'hFFF4, 16'hFFF1, 16'hFFF0));
      check("s3_fd_count", 64'(fd4), 64'(2));

      // 28x28 with random input gaps and random win_ready
      q28.delete(); exp28.delete(); fd28 = 0;
      foreach (img28[i]) img28[i] = 16'($urandom);
      for (int wr = 0; wr < 14; wr++) begin
         for (int wc = 0; wc < 14; wc++) begin
            exp28.push_back({img28[2*wr*28 + 2*wc], img28[2*wr*28 + 2*wc + 1],
                             img28[(2*wr+1)*28 + 2*wc], img28[(2*wr+1)*28 + 2*wc + 1]});
         end
      end
      rand_rdy = 1'b1;
      for (int i = 0; i < 784; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            if28.pix_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         push28(img28[i]);
      end
      if28.pix_valid = 1'b0;
      for (int i = 0; i < 5000 && q28.size() < 196; i++) @(posedge clk);
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      if28.win_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("s4_n_windows", 64'(q28.size()), 64'(196));
      for (int i = 0; i < 196; i++) check($sformatf("s4_w%0d", i), q28[i], exp28[i]);
      check("s4_fd_count", 64'(fd28), 64'(1));

      // Reset after pixel 9, then a fresh frame
      for (int p = 0; p < 10; p++) push4(16'(p));
      if4.pix_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("s5_async_valid", 64'(if4.win_valid), 64'(0));
      check("s5_async_window", {if4.win00, if4.win01, if4.win10, if4.win11}, 64'(0));
      check("s5_async_ready", 64'(if4.pix_ready), 64'(1));
      q4.delete(); fd4 = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int p = 0; p < 16; p++) push4(16'(p));
      if4.pix_valid = 1'b0;
      wait_q4(4);
      check("s5_n_windows", 64'(q4.size()), 64'(4));
      check_base4("s5", 0);
      check("s5_fd_count", 64'(fd4), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
